mmul_rr_scheduler: RTL and testbench
====================================

// Module: mmul_rr_scheduler
// PURPOSE
//  Round-robin scheduler that time-shares one fixed_point_matrix_multiply instance among NREQ requesters
//  (e.g. QR_factorization, Q*R check path, host).
//  Owns the operand-mux select, launches the multiplier, tracks its fixed latency and returns a done pulse
//  to the winning requester. Sits between requesters and the shared immul datapath.
// PARAMETERS
//  NREQ     3   number of requesters (>=2)
//  MUL_LAT  4   cycles from mul_start to valid mul_if.R (>=1)
//  CNTW     16  width of completed-operation counter
// PORTS
//  clk        in   1          single clock, all logic rising-edge
//  reset      in   1          asynchronous, active-low reset (0 = reset)
//  req        in   NREQ       level request per requester; held until done[k] or voluntarily dropped
//  gnt        out  NREQ       one-hot grant; requester k drives operands while gnt[k]=1
//  sel        out  SELW       binary index of granted requester (operand/result mux), SELW=max(1,$clog2(NREQ))
//  mul_start  out  1          one-cycle launch pulse to multiplier
//  done       out  NREQ       one-cycle pulse: result for requester k valid on mul_if.R this cycle
//  busy       out  1          1 in any state other than IDLE
//  op_count   out  CNTW       completed (done-pulsed) operations, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset (async assert, sync-free deassert): state=IDLE, gnt=0, sel=0, mul_start=0, done=0, busy=0,
//   op_count=0, rr pointer=0. Reset mid-operation abandons it; no done is issued.
//  FSM IDLE -> LAUNCH -> WAIT -> DONE -> IDLE:
//   IDLE: if |req, pick winner = first set req at or after pointer (cyclic); register gnt/sel; go LAUNCH.
//         else stay. gnt=0.
//   LAUNCH: mul_start=1 (exactly one cycle). Load cnt=MUL_LAT-1. If MUL_LAT==1 go DONE, else WAIT.
//   WAIT: cnt decrements each cycle; when cnt==1 go DONE (WAIT lasts MUL_LAT-1 cycles).
//   DONE: cycle = mul_start cycle + MUL_LAT. If req[k] still 1: done[k]=1, op_count++.
//         pointer=(k+1) mod NREQ. Go IDLE.
//  gnt/sel stable from LAUNCH through DONE inclusive; drop to 0 the cycle after DONE.
//  Latency: req sampled in IDLE at edge t -> mul_start in cycle t+1 -> done in cycle t+1+MUL_LAT.
//   Minimum inter-op gap: one IDLE cycle.
//  Request dropped mid-op (req[k]=0 during LAUNCH/WAIT): operation still runs to completion (multiplier
//   not cancellable). DONE suppresses done[k] and does not increment op_count. Pointer still advances.
//  New or other requests arriving during an operation are ignored until IDLE; no preemption.
//  Simultaneous requests: strict cyclic priority from pointer, so no requester waits more than NREQ-1 ops.
//  op_count wraps 2^CNTW-1 -> 0 silently.
//  done is at most one-hot; gnt is 0 or one-hot at all times (assertion-checked).
// STRUCTURE
//  linalg_pkg: typedef enum logic[1:0] {S_IDLE,S_LAUNCH,S_WAIT,S_DONE} sched_state_e;
//   function rr_pick(req,ptr) usable by other arbiters.
//  Sub-module rr_arbiter_onehot #(NREQ): combinational rotate-priority pick -> onehot + index + any.
//  Top: FSM, latency counter ($clog2(MUL_LAT+1) bits), pointer, op_count registers.
// TESTING
//  1 Single req=3'b010, MUL_LAT=4 -> gnt=010, sel=1 at t+1, mul_start t+1 only, done=010 at t+5, op_count=1.
//  2 req=3'b111 held -> grant order 0,1,2,0; done pulses every MUL_LAT+2=6 cycles; never two gnt bits set.
//  3 req=3'b101 with pointer=1 after first op -> next grant is 2, then 0.
//  4 req[0] dropped during WAIT -> no done[0], op_count unchanged, state returns IDLE on schedule, pointer=1.
//  5 reset low during WAIT -> all outputs 0 immediately (async); after release req=001 restarts, pointer=0.
//  6 MUL_LAT=1 build: mul_start at t+1, done at t+2; op_count wraps with CNTW=2 after 4 ops (value 0).

Source files
------------

// File: rtl/mmul_rr_scheduler_pkg.sv
// Shared types and helpers for the multiplier scheduler: FSM state encoding,
// select-width helper and a reusable cyclic-priority pick function.
package mmul_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } sched_state_e;

  localparam int unsigned RR_MAXREQ = 32;
  localparam int unsigned RR_IDXW   = 5;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req[nreq-1:0] at or after ptr, wrapping; 0 when none set.
  function automatic logic [RR_IDXW-1:0] rr_pick(input logic [RR_MAXREQ-1:0] req,
                                                 input int unsigned nreq,
                                                 input int unsigned ptr);
    logic [RR_IDXW-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAXREQ; i++) begin
      idx = ptr + i;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (i < nreq) && req[idx[RR_IDXW-1:0]]) begin
        pick  = idx[RR_IDXW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mmul_rr_scheduler_if.sv
// Requester-side bundle of the multiplier scheduler, plus debug visibility of
// the FSM state and round-robin pointer.
interface mmul_rr_scheduler_if #(
  parameter int NREQ = 3,
  parameter int CNTW = 16
);
  import mmul_rr_scheduler_pkg::*;
  localparam int SELW = sel_w(NREQ);

  // Handshake: req[k] is a level held until done[k] pulses (or dropped by the
  // requester); gnt[k] marks when k owns the operand mux; done[k] is a single
  // cycle pulse meaning the result for k is on the multiplier output now.
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel;
  logic            mul_start;
  logic [NREQ-1:0] done;
  logic            busy;
  logic [CNTW-1:0] op_count;
  sched_state_e    dbg_state;
  logic [SELW-1:0] dbg_ptr;

  modport master (
    output req,
    input  gnt, sel, mul_start, done, busy, op_count, dbg_state, dbg_ptr
  );

  modport slave (
    input  req,
    output gnt, sel, mul_start, done, busy, op_count, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/mmul_rr_scheduler_rr_arbiter_onehot.sv
// Combinational rotating-priority arbiter: picks the first request at or after
// the pointer and returns it as one-hot, binary index and an any-request flag.
module rr_arbiter_onehot
  import mmul_rr_scheduler_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int SELW = sel_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);
  logic [RR_MAXREQ-1:0] w_req_ext;
  logic [RR_IDXW-1:0]   w_pick;

  assign w_req_ext = RR_MAXREQ'(i_req);
  assign w_pick    = rr_pick(w_req_ext, unsigned'(NREQ), 32'(i_ptr));
  assign o_idx     = SELW'(w_pick);
  assign o_any     = |i_req;
  assign o_onehot  = o_any ? (NREQ'(1) << o_idx) : '0;
endmodule

// File: rtl/mmul_rr_scheduler.sv
// Time-shares one fixed-latency multiplier among NREQ requesters: grants round
// robin, pulses mul_start, counts the latency and returns a per-requester done.
module mmul_rr_scheduler
  import mmul_rr_scheduler_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MUL_LAT = 4,
  parameter int CNTW    = 16
) (
  input logic                clk,
  input logic                reset,
  mmul_rr_scheduler_if.slave bus
);
  localparam int SELW = sel_w(NREQ);
  localparam int CW   = $clog2(MUL_LAT + 1);

  sched_state_e    r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;
  logic            r_start;
  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [CNTW-1:0] r_count;

  logic [NREQ-1:0] w_onehot;
  logic [SELW-1:0] w_idx;
  logic [SELW-1:0] w_ptr_next;
  logic            w_any;
  logic            w_hit;
  logic            w_to_done;

  rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Winner still requesting on the cycle before DONE decides whether done fires.
  assign w_hit      = |(bus.req & r_gnt);
  assign w_ptr_next = (r_sel == SELW'(NREQ - 1)) ? '0 : r_sel + 1'b1;
  assign w_to_done  = ((r_state == S_LAUNCH) && (MUL_LAT == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == CW'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_sel   <= w_idx;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_cnt   <= CW'(MUL_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Entering DONE overrides the per-state next state above.
      if (w_to_done) begin
        r_state <= S_DONE;
        r_ptr   <= w_ptr_next;
        if (w_hit) begin
          r_done  <= r_gnt;
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.mul_start = r_start;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.op_count  = r_count;
  assign bus.dbg_state = r_state;
  assign bus.dbg_ptr   = r_ptr;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_gnt));
  a_done_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_done));
endmodule

// File: tb/tb_mmul_rr_scheduler.sv
// Bench for the round-robin multiplier scheduler: operation-timeline reference
// model checked every cycle, directed literal checks and randomized requesters.
module tb_mmul_rr_scheduler;
  import mmul_rr_scheduler_pkg::*;

  localparam int NA    = 3;
  localparam int LAT_A = 4;
  localparam int CW_A  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmul_rr_scheduler_if #(.NREQ(NA), .CNTW(CW_A)) bus_a ();
  mmul_rr_scheduler_if #(.NREQ(NA), .CNTW(2))    bus_b ();

  mmul_rr_scheduler #(.NREQ(NA), .MUL_LAT(LAT_A), .CNTW(CW_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  mmul_rr_scheduler #(.NREQ(NA), .MUL_LAT(1), .CNTW(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [NA-1:0] exp_q[$];

  // Reference model: one operation at a time, described by its age in cycles
  // since the launch cycle (0 = launch, LAT_A = done cycle, then one idle cycle).
  bit              m_active;
  int              m_k;
  int              m_age;
  int              m_ptr;
  bit              m_ok;
  logic [CW_A-1:0] m_count;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0;
      m_k      = 0;
      m_age    = 0;
      m_ptr    = 0;
      m_ok     = 0;
      m_count  = '0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_age == LAT_A) begin
        m_active = 0;
      end else begin
        m_age++;
        if (m_age == LAT_A) begin
          m_ok = bus_a.req[m_k];
          if (m_ok) begin
            m_count = m_count + 1'b1;
            exp_q.push_back(NA'(1 << m_k));
          end
          m_ptr = (m_k + 1) % NA;
        end
      end
    end else if (bus_a.req != '0) begin
      for (int i = NA - 1; i >= 0; i--)
        if (bus_a.req[(m_ptr + i) % NA]) m_k = (m_ptr + i) % NA;
      m_active = 1;
      m_age    = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [29:0] act;
    logic [29:0] exp;
    logic [1:0]  st;
    if (!m_active)            st = 2'd0;
    else if (m_age == LAT_A)  st = 2'd3;
    else if (m_age == 0)      st = 2'd1;
    else                      st = 2'd2;
    act = {bus_a.gnt, bus_a.sel, bus_a.mul_start, bus_a.done, bus_a.busy,
           bus_a.op_count, bus_a.dbg_ptr, 2'(bus_a.dbg_state)};
    exp = {(m_active ? NA'(1 << m_k) : NA'(0)),
           (m_active ? 2'(m_k) : 2'd0),
           (m_active && m_age == 0),
           ((m_active && m_age == LAT_A && m_ok) ? NA'(1 << m_k) : NA'(0)),
           m_active,
           m_count,
           2'(m_ptr),
           st};
    check("cycle_outputs", 64'(act), 64'(exp));
    if (bus_a.done != '0) begin
      if (exp_q.size() == 0) check("done_unexpected", 64'(bus_a.done), 64'(0));
      else                   check("done_scoreboard", 64'(bus_a.done), 64'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset     = 1'b0;
    bus_a.req = '0;
    bus_b.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int sels[4];
  int exp_sel2[4] = '{0, 1, 2, 0};
  int exp_cnt6[4] = '{1, 2, 3, 0};
  int cool[NA];
  int nst;
  int last_d;
  bit found;

  initial begin
    bus_a.req = '0;
    bus_b.req = '0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // reset state
    do_reset();
    check("rst_gnt", 64'(bus_a.gnt), 64'(0));
    check("rst_busy", 64'(bus_a.busy), 64'(0));
    check("rst_count", 64'(bus_a.op_count), 64'(0));
    check("rst_ptr", 64'(bus_a.dbg_ptr), 64'(0));

    // single request from requester 1
    bus_a.req = 3'b010;
    tick(1);
    check("t1_gnt", 64'(bus_a.gnt), 64'(3'b010));
    check("t1_sel", 64'(bus_a.sel), 64'(1));
    check("t1_start", 64'(bus_a.mul_start), 64'(1));
    tick(1);
    check("t1_start_once", 64'(bus_a.mul_start), 64'(0));
    check("t1_gnt_hold", 64'(bus_a.gnt), 64'(3'b010));
    tick(3);
    check("t1_done", 64'(bus_a.done), 64'(3'b010));
    check("t1_count", 64'(bus_a.op_count), 64'(1));
    bus_a.req = '0;
    tick(1);
    check("t1_gnt_drop", 64'(bus_a.gnt), 64'(0));
    check("t1_busy_drop", 64'(bus_a.busy), 64'(0));

    // all three held: grant order and done spacing
    do_reset();
    bus_a.req = 3'b111;
    nst    = 0;
    last_d = -1;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (bus_a.mul_start && nst < 4) begin
        sels[nst] = int'(bus_a.sel);
        nst++;
      end
      if (bus_a.done != '0) begin
        if (last_d >= 0) check("t2_done_gap", 64'(c - last_d), 64'(6));
        last_d = c;
      end
    end
    check("t2_nstarts", 64'(nst), 64'(4));
    for (int i = 0; i < 4; i++) check("t2_grant_order", 64'(sels[i]), 64'(exp_sel2[i]));

    // pointer at 1 with req=101 -> 2 then 0
    do_reset();
    bus_a.req = 3'b001;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(1);
      if (bus_a.done[0]) found = 1;
    end
    check("t3_first_done", 64'(found), 64'(1));
    bus_a.req = 3'b101;
    nst = 0;
    for (int c = 0; c < 20 && nst < 2; c++) begin
      tick(1);
      if (bus_a.mul_start) begin
        sels[nst] = int'(bus_a.sel);
        nst++;
      end
    end
    check("t3_nstarts", 64'(nst), 64'(2));
    check("t3_grant_a", 64'(sels[0]), 64'(2));
    check("t3_grant_b", 64'(sels[1]), 64'(0));

    // request dropped during WAIT
    do_reset();
    bus_a.req = 3'b001;
    tick(1);
    check("t4_start", 64'(bus_a.mul_start), 64'(1));
    tick(1);
    bus_a.req = '0;
    tick(3);
    check("t4_state_done", 64'(bus_a.dbg_state), 64'(S_DONE));
    check("t4_no_done", 64'(bus_a.done), 64'(0));
    tick(1);
    check("t4_idle", 64'(bus_a.busy), 64'(0));
    check("t4_count", 64'(bus_a.op_count), 64'(0));
    check("t4_ptr", 64'(bus_a.dbg_ptr), 64'(1));

    // asynchronous reset in the middle of an operation
    do_reset();
    bus_a.req = 3'b001;
    tick(8);
    check("t5_pre_wait", 64'(bus_a.dbg_state), 64'(S_WAIT));
    check("t5_pre_ptr", 64'(bus_a.dbg_ptr), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("t5_gnt", 64'(bus_a.gnt), 64'(0));
    check("t5_busy", 64'(bus_a.busy), 64'(0));
    check("t5_sel", 64'(bus_a.sel), 64'(0));
    check("t5_count", 64'(bus_a.op_count), 64'(0));
    check("t5_ptr", 64'(bus_a.dbg_ptr), 64'(0));
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t5_restart_gnt", 64'(bus_a.gnt), 64'(3'b001));
    check("t5_restart_start", 64'(bus_a.mul_start), 64'(1));
    bus_a.req = '0;
    tick(6);

    // randomized requesters against the model
    do_reset();
    for (int k = 0; k < NA; k++) cool[k] = 0;
    repeat (800) begin
      tick(1);
      for (int k = 0; k < NA; k++) begin
        if (bus_a.req[k]) begin
          if (bus_a.done[k]) begin
            bus_a.req[k] = 1'b0;
            cool[k] = $urandom_range(0, 3);
          end else if ($urandom_range(0, 39) == 0) begin
            bus_a.req[k] = 1'b0;
            cool[k] = LAT_A + 3;
          end
        end else if (cool[k] > 0) begin
          cool[k]--;
        end else if ($urandom_range(0, 2) == 0) begin
          bus_a.req[k] = 1'b1;
        end
      end
    end
    bus_a.req = '0;
    tick(8);

    // single-cycle multiplier build with 2-bit counter
    do_reset();
    bus_b.req = 3'b001;
    for (int op = 0; op < 4; op++) begin
      tick(1);
      check("t6_start", 64'(bus_b.mul_start), 64'(1));
      tick(1);
      check("t6_done", 64'(bus_b.done), 64'(3'b001));
      check("t6_count", 64'(bus_b.op_count), 64'(exp_cnt6[op]));
      tick(1);
      check("t6_idle", 64'(bus_b.busy), 64'(0));
    end
    bus_b.req = '0;
    tick(4);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
